// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and picks the next PC
// from a writable 32-entry branch-target table. Optional macro: FETCH_CYCLE_CNT_EN.
module fetch_unit #(
  parameter int unsigned PC_W    = 10,
  parameter logic [4:0]  HALT_OP = 5'b01111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr,
  output logic            instr_valid,
  input  logic            branch_en,
  input  logic [4:0]      branch_idx,
  input  logic            lut_we,
  input  logic [4:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic            done,
  output logic [15:0]     cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [32];
  logic            run;
  logic            halt;

  assign run  = (state_q == StRun);
  assign halt = run && (imem_data[8:4] == HALT_OP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        // Halt outranks a simultaneous branch; PC then holds on the halt word.
        if (halt) begin
          state_d = StDone;
        end else if (branch_en) begin
          pc_d = lut_q[branch_idx];
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Read is combinational, so a same-cycle write at the branch index returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = run ? imem_data : 9'b0;
  assign instr_valid = run;
  assign done        = (state_q == StDone);

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cnt_q;
  logic        accept;

  assign accept = start && (state_q != StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses are queued per program and
// popped as the DUT presents valid instructions. A second PC_W=4 instance covers PC wrap.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'b011110000;
  localparam logic [8:0] NOP  = 9'b000000001;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic [8:0]  instr;
  logic        instr_valid;
  logic        branch_en;
  logic [4:0]  branch_idx;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [9:0]  lut_wdata;
  logic        done;
  logic [15:0] cycle_count;

  logic        s_start;
  logic [3:0]  s_imem_addr;
  logic [8:0]  s_imem_data;
  logic [8:0]  s_instr;
  logic        s_instr_valid;
  logic        s_branch_en;
  logic [4:0]  s_branch_idx;
  logic        s_lut_we;
  logic [4:0]  s_lut_waddr;
  logic [3:0]  s_lut_wdata;
  logic        s_done;
  logic [15:0] s_cycle_count;

  // Program memory plus a decoder stub keyed on fetch address.
  logic [8:0]  mem        [1024];
  logic        br_en_mem  [1024];
  logic [4:0]  br_idx_mem [1024];
  logic [8:0]  mem4       [16];

  assign imem_data   = mem[imem_addr];
  assign branch_en   = br_en_mem[imem_addr];
  assign branch_idx  = br_idx_mem[imem_addr];
  assign s_imem_data = mem4[s_imem_addr];

  fetch_unit #(.PC_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .branch_en  (branch_en),
    .branch_idx (branch_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .done       (done),
    .cycle_count(cycle_count)
  );

  fetch_unit #(.PC_W(4)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .imem_addr  (s_imem_addr),
    .imem_data  (s_imem_data),
    .instr      (s_instr),
    .instr_valid(s_instr_valid),
    .branch_en  (s_branch_en),
    .branch_idx (s_branch_idx),
    .lut_we     (s_lut_we),
    .lut_waddr  (s_lut_waddr),
    .lut_wdata  (s_lut_wdata),
    .done       (s_done),
    .cycle_count(s_cycle_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int hook_addr = -1;
  int poke_addr = -1;
  logic [4:0] hook_idx;
  logic [9:0] hook_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cc(input int n);
`ifdef FETCH_CYCLE_CNT_EN
    return n;
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      mem[i]        = NOP;
      br_en_mem[i]  = 1'b0;
      br_idx_mem[i] = '0;
    end
  endtask

  task automatic lut_write(input logic [4:0] idx, input logic [9:0] data);
    @(negedge clk);
    lut_we    = 1'b1;
    lut_waddr = idx;
    lut_wdata = data;
    @(negedge clk);
    lut_we    = 1'b0;
  endtask

  // Start a run and compare each valid fetch against the queue; max bounds the wait.
  task automatic run(input int max, input bit exp_done);
    int n;
    int e;
    logic [31:0] last;
    n    = 0;
    last = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_clr", done, 0);
    for (int c = 0; c < max; c++) begin
      lut_we = 1'b0;
      start  = 1'b0;
      if (!instr_valid) break;
      n++;
      if (exp_q.size() == 0) begin
        check_eq("extra_fetch", imem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("pc", imem_addr, e);
        check_eq("instr", instr, mem[e]);
      end
      last = imem_addr;
      if (int'(imem_addr) == hook_addr) begin
        lut_we    = 1'b1;
        lut_waddr = hook_idx;
        lut_wdata = hook_data;
      end
      if (int'(imem_addr) == poke_addr) start = 1'b1;
      if (c == max - 1 && !exp_done) break;
      @(negedge clk);
    end
    check_eq("q_empty", exp_q.size(), 0);
    if (exp_done) begin
      check_eq("halted", instr_valid, 0);
      check_eq("done", done, 1);
      check_eq("instr_idle", instr, 0);
      check_eq("cycles", cycle_count, exp_cc(n));
      @(negedge clk);
      check_eq("pc_hold", imem_addr, last);
      check_eq("done_hold", done, 1);
    end
  endtask

  initial begin
    int n;
    int e;
    bit first;
    rst_n = 1'b0;
    start = 1'b0;
    lut_we = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
    s_start = 1'b0;
    s_branch_en = 1'b0;
    s_branch_idx = '0;
    s_lut_we = 1'b0;
    s_lut_waddr = '0;
    s_lut_wdata = '0;
    for (int i = 0; i < 16; i++) mem4[i] = NOP;
    clear_prog();

    #12;
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_cycles", cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line program ending in halt.
    mem[1] = 9'b000000010;
    mem[2] = HALT;
    exp_q = '{0, 1, 2};
    run(20, 1'b1);

    // Branch through lut[5]; a start pulse mid-run must be ignored.
    clear_prog();
    lut_write(5'd5, 10'd100);
    br_en_mem[3] = 1'b1;
    br_idx_mem[3] = 5'd5;
    mem[102] = HALT;
    poke_addr = 1;
    exp_q = '{0, 1, 2, 3, 100, 101, 102};
    run(20, 1'b1);
    poke_addr = -1;

    // Same-cycle write and read of lut[7] returns the old target.
    clear_prog();
    lut_write(5'd7, 10'd50);
    br_en_mem[1] = 1'b1;
    br_idx_mem[1] = 5'd7;
    mem[50] = HALT;
    mem[200] = HALT;
    hook_addr = 1;
    hook_idx = 5'd7;
    hook_data = 10'd200;
    exp_q = '{0, 1, 50};
    run(20, 1'b1);
    hook_addr = -1;
    exp_q = '{0, 1, 200};
    run(20, 1'b1);

    // Halt together with branch_en: halt wins, then restart from 0.
    clear_prog();
    mem[2] = HALT;
    br_en_mem[2] = 1'b1;
    br_idx_mem[2] = 5'd5;
    exp_q = '{0, 1, 2};
    run(20, 1'b1);
    exp_q = '{0, 1, 2};
    run(20, 1'b1);

    // PC wrap on the 4-bit instance.
    mem4[1] = HALT;
    @(negedge clk);
    s_lut_we = 1'b1;
    s_lut_waddr = 5'd1;
    s_lut_wdata = 4'd14;
    @(negedge clk);
    s_lut_we = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    exp_q = '{0, 14, 15, 0, 1};
    n = 0;
    first = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_branch_en = 1'b0;
      if (!s_instr_valid) break;
      n++;
      if (exp_q.size() == 0) begin
        check_eq("w_extra", s_imem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("w_pc", s_imem_addr, e);
      end
      if (first) begin
        s_branch_en = 1'b1;
        s_branch_idx = 5'd1;
        first = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("w_q_empty", exp_q.size(), 0);
    check_eq("w_done", s_done, 1);
    check_eq("w_cycles", s_cycle_count, exp_cc(n));
    @(negedge clk);
    check_eq("w_pc_hold", s_imem_addr, 1);

    // Asynchronous reset mid-run at PC 37.
    clear_prog();
    for (int i = 0; i < 38; i++) exp_q.push_back(i);
    run(38, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("arst_addr", imem_addr, 0);
    check_eq("arst_valid", instr_valid, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_instr", instr, 0);
    check_eq("arst_cycles", cycle_count, 0);
    check_eq("arst_w_done", s_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // lut[7] held 200 before reset; it must now read 0.
    br_en_mem[2] = 1'b1;
    br_idx_mem[2] = 5'd7;
    exp_q = '{0, 1, 2, 0};
    run(4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter and drives the instruction memory address. Presents the 9-bit instruction word to the decoder and takes back the decoder's `branchEnable` / `branchLUTIndex` to pick the next PC from a writable 32-entry branch-target table. A start/done handshake frames each program run, and a dedicated halt opcode ends it.

## Interface
Parameters:
- `PC_W`, 10, program counter / instruction address width
- `HALT_OP`, 5'b01111, value of `instr[8:4]` that halts (M-type sub-op 111, unused by the decoder)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a program run from PC 0; sampled in IDLE or DONE only
- `imem_addr`  out  PC_W  instruction memory address, equals PC
- `imem_data`  in  9  instruction word, combinational read of `imem_addr`
- `instr`  out  9  instruction to decoder; `imem_data` while RUN, else 9'b0
- `instr_valid`  out  1  high only in RUN; downstream gates all writes with it
- `branch_en`  in  1  decoder `branchEnable`
- `branch_idx`  in  5  decoder `branchLUTIndex`
- `lut_we`  in  1  branch-table write strobe
- `lut_waddr`  in  5  branch-table write index
- `lut_wdata`  in  PC_W  branch target written
- `done`  out  1  high in DONE until the next accepted `start`
- `cycle_count`  out  16  RUN-cycle counter (see Configuration)

## Operation
- States: IDLE (reset), RUN, DONE.
- IDLE: PC = 0, `done` = 0, `instr_valid` = 0. On `start`, go to RUN with PC = 0.
- RUN: each cycle, evaluate the following in priority order:
  1. `instr[8:4] == HALT_OP`: go to DONE; PC holds.
  2. Else if `branch_en`: PC <= `lut[branch_idx]`.
  3. Else: PC <= PC + 1, modulo 2^PC_W (wraps from all-ones to 0 with no error).
- `start` in RUN is ignored.
- DONE: `done` = 1, PC holds, `instr_valid` = 0. On `start`, go to RUN with PC = 0 and `done` = 0.
- Branch table: 32 x PC_W registers, all reset to 0.
  - Write port is synchronous, active in any state.
  - Read port is combinational.
  - A same-cycle write and branch read at the same index returns the old entry; the new value is visible next cycle.
- `branch_en` is ignored outside RUN.

## Timing
- Reset values:
  - state IDLE, PC 0, every table entry 0
  - `done` 0, `instr_valid` 0, `instr` 0, `imem_addr` 0
  - `cycle_count` 0
- Reset takes effect immediately when asserted (asynchronous), including mid-run; all outputs return to reset values within the same cycle.
- `start` high at edge n (IDLE or DONE): RUN from n+1, `imem_addr` = 0, `instr_valid` = 1.
- Fetch-to-next-PC latency is 1 cycle: the branch decision made on the cycle-k instruction is the address presented in cycle k+1. No bubble, no delay slot.
- Halt fetched in cycle k: `done` = 1 and `instr_valid` = 0 from cycle k+1. The halt word itself is presented with `instr_valid` = 1 for one cycle.
- Halt and `branch_en` in the same cycle: halt wins.

## Configuration
- `FETCH_CYCLE_CNT_EN` defined:
  - `cycle_count` increments on every RUN cycle, including the halt cycle.
  - It clears to 0 on each accepted `start`, holds in IDLE and DONE, and saturates at 16'hFFFF.
- Not defined: `cycle_count` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then `start` pulse; memory holds ADD, ADD, halt (9'b011110000) at addresses 0-2:
  - `imem_addr` reads 0, 1, 2 with `instr_valid` = 1.
  - `done` rises the cycle after address 2.
  - With the macro defined, `cycle_count` = 3.
- Write `lut[5]` = 10'd100, then run with `branch_en` = 1 and `branch_idx` = 5 at PC 3 -> next `imem_addr` = 100, then 101.
- `lut_we` to index 7 (value 200) in the same cycle as `branch_en` with idx 7 (old value 50) -> PC = 50. Repeating the branch later -> PC = 200.
- PC_W = 4, program of no-ops with halt at address 1 after a wrap -> PC sequence 14, 15, 0, 1, then DONE.
- Halt word with `branch_en` = 1 -> PC holds and state goes to DONE. A later `start` -> PC = 0 and `done` = 0.
- `rst_n` pulsed low mid-run at PC 37 -> immediately `imem_addr` = 0, `instr_valid` = 0, `done` = 0, all table entries 0, state IDLE.
